// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : I2C target with a 16 x 8-bit register file. SCL/SDA are
//            oversampled on clk, synchronised and glitch-filtered. START,
//            repeated START and STOP are decoded. One 7-bit address is
//            matched. A write sets a register pointer and stores data bytes.
//            A read returns bytes starting at the pointer. A host side port
//            preloads and inspects the registers.
// Ports    : clk, reset       - system clock, synchronous active-high reset
//            scl_in, sda_in   - raw pad inputs
//            sda_oe           - 1 = pull SDA low (open drain)
//            host_we/addr/wdata, host_rdata - host register-file access
//            rx_valid/addr/data - pulse and record for each stored bus byte
//            busy             - from address match until STOP
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       rx_valid,
  output logic [3:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       busy
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ADDR       = 4'd1;
  localparam logic [3:0] S_ADDR_ACK   = 4'd2;
  localparam logic [3:0] S_WR_PTR     = 4'd3;
  localparam logic [3:0] S_WR_PTR_ACK = 4'd4;
  localparam logic [3:0] S_WR_DATA    = 4'd5;
  localparam logic [3:0] S_WR_ACK     = 4'd6;
  localparam logic [3:0] S_RD_DATA    = 4'd7;
  localparam logic [3:0] S_RD_ACK     = 4'd8;
  localparam logic [3:0] S_WAIT_STOP  = 4'd9;

  // Bit 1 = SCL, bit 0 = SDA.
  logic [1:0] raw_pins;
  logic [1:0] filt;
  logic [1:0] filt_prev_q;

  assign raw_pins = {scl_in, sda_in};

  // Two-flop synchroniser followed by a run-length filter: the filtered
  // value only follows the synchronised one after FILTER_LEN consecutive
  // differing samples. Flops reset high to match an idle bus.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_pins[gi];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign filt[gi] = filt_q;
  end

  logic scl_f, sda_f;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  =  scl_f & ~filt_prev_q[1];
  assign scl_fall  = ~scl_f &  filt_prev_q[1];
  assign sda_rise  =  sda_f & ~filt_prev_q[0];
  assign sda_fall  = ~sda_f &  filt_prev_q[0];
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  logic [3:0] state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q;
  logic [3:0] rx_addr_q;
  logic [7:0] rx_data_q;
  logic [7:0] regs_q [16];
  logic [7:0] rd_byte;
  logic       store;
  logic       load_rd;

  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    store    = 1'b0;
    load_rd  = 1'b0;
    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_WR_PTR, S_WR_DATA: begin
          // Shift on SCL rise; a complete byte is acted on at the SCL fall
          // that follows the 8th bit, which also opens the ACK slot.
          if (scl_rise && (bitcnt_q != 4'd8)) begin
            shift_d  = {shift_q[6:0], sda_f};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && (bitcnt_q == 4'd8)) begin
            bitcnt_d = '0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = S_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else if (state_q == S_WR_PTR) begin
              ptr_d    = shift_q[3:0];
              state_d  = S_WR_PTR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              store    = 1'b1;
              ptr_d    = ptr_q + 4'd1;
              state_d  = S_WR_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          // shift_q[0] still holds the R/W bit of the address byte.
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (shift_q[0]) begin
              load_rd = 1'b1;
            end else begin
              state_d = S_WR_PTR;
            end
          end
        end
        S_WR_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          // The MSB went out on entry; each fall here drives the next bit,
          // and the 8th fall frees SDA for the master's ACK.
          if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda_f) begin
            state_d = S_WAIT_STOP;
          end else if (scl_fall) begin
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_rd) begin
        shift_d  = rd_byte;
        ptr_d    = ptr_q + 4'd1;
        sda_oe_d = ~rd_byte[7];
        bitcnt_d = '0;
        state_d  = S_RD_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_prev_q <= 2'b11;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      filt_prev_q <= filt;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_valid_q  <= store;
      if (store) begin
        rx_addr_q <= ptr_q;
        rx_data_q <= shift_q;
      end
      if (host_we) begin
        regs_q[host_addr] <= host_wdata;
      end
      // Later assignment: a bus store overrides a same-cycle host write.
      if (store) begin
        regs_q[ptr_q] <= shift_q;
      end
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign rx_valid   = rx_valid_q;
  assign rx_addr    = rx_addr_q;
  assign rx_data    = rx_data_q;
  assign host_rdata = regs_q[host_addr];

endmodule
`default_nettype wire

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

I2C target (slave) with a 16 × 8-bit register file; the responder end of the team's I2C master FSM. It sits behind the GPIO open-drain pads and oversamples SCL/SDA on the system clock. It decodes START, repeated START and STOP, matches a 7-bit address and ACKs it. Writes set a register pointer and store data bytes; reads return bytes from the pointer. The host logic has a side port to preload the values the master reads back.

## Interface
- `SLAVE_ADDR`, 7'h3C: 7-bit bus address this target answers.
- `FILTER_LEN`, 3: consecutive equal samples required before a pin change is accepted.
- `clk` in 1: system clock, ≥ 20× SCL rate.
- `reset` in 1: synchronous, active-high; clears all state.
- `scl_in` in 1: raw SCL from pad.
- `sda_in` in 1: raw SDA from pad.
- `sda_oe` out 1: 1 = pull SDA low; the top level drives the pad to 0 when set, else Z. The block never drives SCL.
- `host_we` in 1: host write strobe into the register file.
- `host_addr` in 4: host write/read index.
- `host_wdata` in 8: host write data.
- `host_rdata` out 8: combinational read of `reg[host_addr]`.
- `rx_valid` out 1: one-cycle pulse when a data byte from the master is stored.
- `rx_addr` out 4, `rx_data` out 8: index/value of the stored byte; held until the next pulse.
- `busy` out 1: high from an accepted address match until STOP.

## Operation
- Input conditioning: 2-flop synchronizer, then a filter. The filtered value updates only after `FILTER_LEN` identical synchronized samples. SCL rise/fall and SDA edges are single-cycle strobes on the filtered signals.
- START or repeated START: filtered SDA falls while filtered SCL is high. From any state, go to ADDR, clear the bit counter, and release `sda_oe`.
- STOP: filtered SDA rises while filtered SCL is high. From any state, go to IDLE, release `sda_oe`, and drop `busy`.
- States:
  - IDLE: wait for START.
  - ADDR: shift SDA on 8 SCL rises, MSB first.
  - ADDR_ACK: on address match, ACK and go to WR_PTR (R/W=0) or RD_DATA (R/W=1). On mismatch, go to WAIT_STOP with no ACK.
  - WR_PTR: receive 8 bits; the low 4 bits load the pointer.
  - WR_PTR_ACK: ACK, then go to WR_DATA.
  - WR_DATA: receive 8 bits.
  - WR_ACK: ACK; store `reg[ptr]`; pulse `rx_valid`; `ptr <= ptr+1`; return to WR_DATA.
  - RD_DATA: shift out the loaded byte.
  - RD_ACK: sample the master's bit on SCL rise. 0 = ACK: load the next byte and return to RD_DATA. 1 = NACK: go to WAIT_STOP.
  - WAIT_STOP: `sda_oe`=0; only START or STOP are acted on.
- ACK: assert `sda_oe` on the SCL fall after the 8th bit; release it on the following SCL fall.
- Read data:
  - On entry to RD_DATA, load `reg[ptr]` and set `ptr <= ptr+1`.
  - Drive each bit on an SCL fall with `sda_oe = ~bit`. The MSB is driven on the SCL fall that ends the address/ACK slot.
  - After the 8th bit's SCL fall, release SDA for the master's ACK.
- Pointer: 4 bits, wraps 15→0. It is retained across repeated START and STOP; only reset clears it.
- Host/bus collision: if `host_we` and an I2C store hit the same cycle, the I2C store wins.

## Timing
- Reset values:
  - `sda_oe`=0, `rx_valid`=0, `rx_addr`=0, `rx_data`=0, `busy`=0.
  - pointer 0, all registers 8'h00, state IDLE.
- Pin-to-filtered latency: 2 + `FILTER_LEN` cycles. Pulses shorter than `FILTER_LEN` cycles are ignored.
- `sda_oe` changes 1 cycle after the filtered SCL-fall strobe.
- `rx_valid`, the register store and `busy` rise 1 cycle after the SCL fall that starts the ACK.
- `host_rdata` reflects a host or I2C store on the next cycle.
- Reset mid-transfer returns to IDLE the next cycle with SDA released. The bus master must then see a NACK or its own timeout.

## Test plan
- Write: START, 0x78 (addr 3C, W), ptr 0x05, data 0xA5, 0x5A, STOP → ACK on all 4 bytes; `rx_valid` pulses with (5, A5) then (6, 5A); `host_rdata` at 5/6 returns A5/5A.
- Address mismatch: START, 0x7A → `sda_oe` stays 0 throughout; no `rx_valid`; `busy` stays 0; subsequent data bytes ignored until STOP.
- Read with wrap:
  - Host preloads reg15=0x81, reg0=0x7E.
  - Bus sequence: write ptr 0x0F, repeated START, 0x79, read 2 bytes (master ACK then NACK), STOP.
  - Required response: SDA carries 0x81 then 0x7E; `sda_oe` released in both master ACK slots and after the NACK.
- STOP mid-byte after 3 data bits → IDLE immediately; no store; `busy`=0; a new transaction then succeeds.
- Glitch: a 1-cycle low pulse on `scl_in` and a 2-cycle pulse on `sda_in` while SCL is high → no bit shifted, no START/STOP detected.
- Reset asserted during a read's 4th bit with `sda_oe`=1 → next cycle `sda_oe`=0, IDLE, pointer 0, registers 0.
